// File: rtl/run_detector.sv
// -----------------------------------------------------------------------------
// run_detector
// Serial run-of-ones detector. Counts consecutive sampled 1s on x_in and
// flags a hit when the run reaches RUN_LEN. MODE selects the detect output
// behaviour:
//   0 = level (high for as long as the run is at or past RUN_LEN)
//   1 = single pulse (high only on the sample that reaches RUN_LEN)
//   2 = repeating pulse (non-overlapping restart, one hit per RUN_LEN ones)
//
// Ports
//   clk       : clock, all state changes on rising edge
//   rstn      : asynchronous active-low reset
//   en        : sample enable, x_in consumed only when high
//   clr       : synchronous clear, priority over en and x_in
//   x_in      : serial data bit
//   y_out     : detect output, registered, decoded from the FSM state
//   state     : current FSM state (00 idle, 01 run, 10 hit, 11 long)
//   run_len   : current count of consecutive sampled 1s (saturating)
//   match_cnt : number of hits since reset or clr (wraps modulo 2^MW)
//   match_ovf : sticky flag, set when match_cnt wraps
// -----------------------------------------------------------------------------
module run_detector #(
    parameter int RUN_LEN = 3,
    parameter int CW      = 4,
    parameter int MW      = 8,
    parameter int MODE    = 0
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          en,
    input  logic          clr,
    input  logic          x_in,
    output logic          y_out,
    output logic [1:0]    state,
    output logic [CW-1:0] run_len,
    output logic [MW-1:0] match_cnt,
    output logic          match_ovf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_HIT  = 2'b10,
        S_LONG = 2'b11
    } state_t;

    localparam logic [CW-1:0] RL_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] RL_TGT = CW'(RUN_LEN);
    localparam logic [CW-1:0] RL_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [MW-1:0] MC_MAX = {MW{1'b1}};
    localparam logic [MW-1:0] MC_ONE = {{(MW-1){1'b0}}, 1'b1};

    state_t        r_state;
    logic [CW-1:0] r_run_len;
    logic [MW-1:0] r_match_cnt;
    logic          r_match_ovf;
    logic          r_y_out;

    state_t        w_state_nxt;
    logic [CW-1:0] w_run_nxt;
    logic [CW-1:0] w_run_inc;
    logic [MW-1:0] w_cnt_nxt;
    logic          w_ovf_nxt;
    logic          w_y_nxt;

    // Detect output as a pure function of a state value; y_out is the
    // registered copy of this decode applied to the next state, so it always
    // matches the state register and never sees x_in combinationally.
    function automatic logic decode_y(input state_t s);
        logic y;
        case (s)
            S_HIT:   y = 1'b1;
            S_LONG:  y = (MODE == 0) ? 1'b1 : 1'b0;
            default: y = 1'b0;
        endcase
        return y;
    endfunction

    // Next-state, run-length and match-counter logic.
    always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run_len;
        w_cnt_nxt   = r_match_cnt;
        w_ovf_nxt   = r_match_ovf;
        w_run_inc   = (r_run_len == RL_MAX) ? RL_MAX : (r_run_len + RL_ONE);

        if (clr) begin
            w_state_nxt = S_IDLE;
            w_run_nxt   = {CW{1'b0}};
            w_cnt_nxt   = {MW{1'b0}};
            w_ovf_nxt   = 1'b0;
        end else if (en) begin
            if (!x_in) begin
                w_state_nxt = S_IDLE;
                w_run_nxt   = {CW{1'b0}};
            end else if ((MODE == 2) && (r_state == S_HIT)) begin
                // Non-overlapping restart: this 1 is the first of the next run.
                w_state_nxt = S_RUN;
                w_run_nxt   = RL_ONE;
            end else begin
                w_run_nxt = w_run_inc;
                case (r_state)
                    S_HIT, S_LONG: w_state_nxt = S_LONG;
                    default: begin
                        if (w_run_inc == RL_TGT) begin
                            w_state_nxt = S_HIT;
                        end else if (w_run_inc < RL_TGT) begin
                            w_state_nxt = S_RUN;
                        end else begin
                            w_state_nxt = S_LONG;
                        end
                    end
                endcase
            end

            // S_HIT never loops on itself, so entering it is exactly one hit.
            if (w_state_nxt == S_HIT) begin
                w_cnt_nxt = r_match_cnt + MC_ONE;
                w_ovf_nxt = (r_match_cnt == MC_MAX) ? 1'b1 : r_match_ovf;
            end else begin
                w_cnt_nxt = r_match_cnt;
                w_ovf_nxt = r_match_ovf;
            end
        end else begin
            w_state_nxt = r_state;
            w_run_nxt   = r_run_len;
        end

        w_y_nxt = decode_y(w_state_nxt);
    end

    // State, counters and registered detect output.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_run_len   <= {CW{1'b0}};
            r_match_cnt <= {MW{1'b0}};
            r_match_ovf <= 1'b0;
            r_y_out     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_run_len   <= w_run_nxt;
            r_match_cnt <= w_cnt_nxt;
            r_match_ovf <= w_ovf_nxt;
            r_y_out     <= w_y_nxt;
        end
    end

    assign y_out     = r_y_out;
    assign state     = r_state;
    assign run_len   = r_run_len;
    assign match_cnt = r_match_cnt;
    assign match_ovf = r_match_ovf;

endmodule

// File: tb/tb_run_detector.sv
// -----------------------------------------------------------------------------
// tb_run_detector
// Directed bench for run_detector. Four instances share one stimulus stream:
//   u_m0 : MODE 0, RUN_LEN 3, CW 4, MW 8
//   u_m1 : MODE 1, RUN_LEN 3, CW 4, MW 8
//   u_m2 : MODE 2, RUN_LEN 3, CW 4, MW 8
//   u_mw : MODE 0, RUN_LEN 3, CW 4, MW 2 (match counter wrap)
// Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_run_detector;

    logic clk = 1'b0;
    logic rstn, en, clr, x_in;

    logic       y0, y1, y2, yw;
    logic [1:0] st0, st1, st2, stw;
    logic [3:0] rl0, rl1, rl2, rlw;
    logic [7:0] mc0, mc1, mc2;
    logic [1:0] mcw;
    logic       ov0, ov1, ov2, ovw;

    int n_vec = 0;
    int n_err = 0;

    run_detector #(.RUN_LEN(3), .CW(4), .MW(8), .MODE(0)) u_m0 (
        .clk(clk), .rstn(rstn), .en(en), .clr(clr), .x_in(x_in),
        .y_out(y0), .state(st0), .run_len(rl0), .match_cnt(mc0), .match_ovf(ov0));
    run_detector #(.RUN_LEN(3), .CW(4), .MW(8), .MODE(1)) u_m1 (
        .clk(clk), .rstn(rstn), .en(en), .clr(clr), .x_in(x_in),
        .y_out(y1), .state(st1), .run_len(rl1), .match_cnt(mc1), .match_ovf(ov1));
    run_detector #(.RUN_LEN(3), .CW(4), .MW(8), .MODE(2)) u_m2 (
        .clk(clk), .rstn(rstn), .en(en), .clr(clr), .x_in(x_in),
        .y_out(y2), .state(st2), .run_len(rl2), .match_cnt(mc2), .match_ovf(ov2));
    run_detector #(.RUN_LEN(3), .CW(4), .MW(2), .MODE(0)) u_mw (
        .clk(clk), .rstn(rstn), .en(en), .clr(clr), .x_in(x_in),
        .y_out(yw), .state(stw), .run_len(rlw), .match_cnt(mcw), .match_ovf(ovw));

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic x, input logic e, input logic c);
        x_in = x;
        en   = e;
        clr  = c;
        @(posedge clk);
        #1;
    endtask

    logic [1:0] a_st0 [5] = '{2'd1, 2'd1, 2'd2, 2'd3, 2'd0};
    logic       a_y0  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [1:0] a_st1 [5] = '{2'd1, 2'd1, 2'd2, 2'd3, 2'd0};
    logic       a_y1  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0] a_st2 [5] = '{2'd1, 2'd1, 2'd2, 2'd1, 2'd0};
    logic [3:0] a_rl0 [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    logic       a_x   [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [1:0] c_st2 [7] = '{2'd1, 2'd1, 2'd2, 2'd1, 2'd1, 2'd2, 2'd1};
    logic       c_y2  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0] c_rl2 [7] = '{4'd1, 4'd2, 4'd3, 4'd1, 4'd2, 4'd3, 4'd1};

    initial begin
        rstn = 1'b0;
        en   = 1'b0;
        clr  = 1'b0;
        x_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_y0", 32'(y0), 32'd0);
        chk("rst_st0", 32'(st0), 32'd0);
        chk("rst_rl0", 32'(rl0), 32'd0);
        chk("rst_mc0", 32'(mc0), 32'd0);
        chk("rst_ov0", 32'(ov0), 32'd0);
        chk("rst_stw", 32'(stw), 32'd0);
        chk("rst_mcw", 32'(mcw), 32'd0);
        rstn = 1'b1;

        // Stream 1,1,1,1,0 across modes 0/1/2.
        for (int i = 0; i < 5; i++) begin
            step(a_x[i], 1'b1, 1'b0);
            chk($sformatf("a_st0_%0d", i), 32'(st0), 32'(a_st0[i]));
            chk($sformatf("a_y0_%0d", i),  32'(y0),  32'(a_y0[i]));
            chk($sformatf("a_rl0_%0d", i), 32'(rl0), 32'(a_rl0[i]));
            chk($sformatf("a_st1_%0d", i), 32'(st1), 32'(a_st1[i]));
            chk($sformatf("a_y1_%0d", i),  32'(y1),  32'(a_y1[i]));
            chk($sformatf("a_st2_%0d", i), 32'(st2), 32'(a_st2[i]));
        end
        chk("a_mc0", 32'(mc0), 32'd1);
        chk("a_mc1", 32'(mc1), 32'd1);
        chk("a_mc2", 32'(mc2), 32'd1);
        chk("a_mcw", 32'(mcw), 32'd1);

        // Clear with en=1, x_in=1: clear must win.
        step(1'b1, 1'b1, 1'b1);
        chk("clr_st0", 32'(st0), 32'd0);
        chk("clr_rl0", 32'(rl0), 32'd0);
        chk("clr_mc0", 32'(mc0), 32'd0);
        chk("clr_y0", 32'(y0), 32'd0);
        chk("clr_mcw", 32'(mcw), 32'd0);
        chk("clr_st2", 32'(st2), 32'd0);

        // Seven consecutive 1s: MODE 2 hits after the 3rd and 6th.
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 1'b1, 1'b0);
            chk($sformatf("c_st2_%0d", i), 32'(st2), 32'(c_st2[i]));
            chk($sformatf("c_y2_%0d", i),  32'(y2),  32'(c_y2[i]));
            chk($sformatf("c_rl2_%0d", i), 32'(rl2), 32'(c_rl2[i]));
        end
        chk("c_mc2", 32'(mc2), 32'd2);
        chk("c_st0", 32'(st0), 32'd3);
        chk("c_rl0", 32'(rl0), 32'd7);
        chk("c_y0", 32'(y0), 32'd1);
        chk("c_mc0", 32'(mc0), 32'd1);
        chk("c_mcw", 32'(mcw), 32'd1);
        step(1'b0, 1'b1, 1'b0);
        chk("c_idle_st0", 32'(st0), 32'd0);
        chk("c_idle_y0", 32'(y0), 32'd0);

        // Enable gap: 1,1, three disabled 0s, then 1 -> hit.
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("d_rl0_pre", 32'(rl0), 32'd2);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0);
            chk($sformatf("d_hold_st0_%0d", i), 32'(st0), 32'd1);
            chk($sformatf("d_hold_rl0_%0d", i), 32'(rl0), 32'd2);
        end
        step(1'b1, 1'b1, 1'b0);
        chk("d_st0", 32'(st0), 32'd2);
        chk("d_y0", 32'(y0), 32'd1);
        chk("d_rl0", 32'(rl0), 32'd3);
        chk("d_mc0", 32'(mc0), 32'd2);
        chk("d_mcw", 32'(mcw), 32'd2);
        // Disabled 1 is ignored: no state change, no extra hit.
        step(1'b1, 1'b0, 1'b0);
        chk("d_dis_st0", 32'(st0), 32'd2);
        chk("d_dis_y0", 32'(y0), 32'd1);
        chk("d_dis_mc0", 32'(mc0), 32'd2);
        step(1'b0, 1'b1, 1'b0);

        // Two more hits on the MW=2 instance: 3, then wrap to 0.
        repeat (3) step(1'b1, 1'b1, 1'b0);
        chk("e_mcw3", 32'(mcw), 32'd3);
        chk("e_ovw3", 32'(ovw), 32'd0);
        step(1'b0, 1'b1, 1'b0);
        repeat (3) step(1'b1, 1'b1, 1'b0);
        chk("e_mcw_wrap", 32'(mcw), 32'd0);
        chk("e_ovw_set", 32'(ovw), 32'd1);
        chk("e_mc0", 32'(mc0), 32'd4);
        step(1'b0, 1'b1, 1'b0);
        chk("e_ovw_hold", 32'(ovw), 32'd1);
        step(1'b0, 1'b1, 1'b1);
        chk("e_clr_mcw", 32'(mcw), 32'd0);
        chk("e_clr_ovw", 32'(ovw), 32'd0);
        chk("e_clr_stw", 32'(stw), 32'd0);
        chk("e_clr_yw", 32'(yw), 32'd0);
        chk("e_clr_rlw", 32'(rlw), 32'd0);

        // Saturation: 16 ones with CW=4 holds run_len at 15 in S_LONG.
        repeat (15) step(1'b1, 1'b1, 1'b0);
        chk("s_rl0_15", 32'(rl0), 32'd15);
        step(1'b1, 1'b1, 1'b0);
        chk("s_rl0_sat", 32'(rl0), 32'd15);
        chk("s_st0", 32'(st0), 32'd3);
        chk("s_y0", 32'(y0), 32'd1);
        chk("s_st1", 32'(st1), 32'd3);
        chk("s_y1", 32'(y1), 32'd0);
        chk("s_mc0", 32'(mc0), 32'd1);
        step(1'b0, 1'b1, 1'b0);

        // Reset mid-run discards the partial run.
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("f_rl0_pre", 32'(rl0), 32'd2);
        rstn = 1'b0;
        #2;
        chk("f_async_rl0", 32'(rl0), 32'd0);
        chk("f_async_st0", 32'(st0), 32'd0);
        chk("f_async_mc0", 32'(mc0), 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("f_rl0", 32'(rl0), 32'd2);
        chk("f_st0", 32'(st0), 32'd1);
        chk("f_y0", 32'(y0), 32'd0);
        chk("f_mc0", 32'(mc0), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
